// File: rtl/store_buffer.sv
// In-order store buffer: allocates at rename, captures execute results, commits in ROB order
// and drains committed stores to the D-cache write port. Flush drops uncommitted entries.
module store_buffer #(
    parameter int unsigned SB_DEPTH     = 16,
    parameter int unsigned SB_IDX_WIDTH = $clog2(SB_DEPTH),
    parameter int unsigned PLEN         = 32,
    parameter int unsigned XLEN         = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    alloc_req_i,
    output logic                    alloc_gnt_o,
    output logic [SB_IDX_WIDTH-1:0] alloc_id_o,
    input  logic                    ex_valid_i,
    input  logic [SB_IDX_WIDTH-1:0] ex_sb_id_i,
    input  logic [PLEN-1:0]         ex_addr_i,
    input  logic [XLEN-1:0]         ex_data_i,
    input  logic [XLEN/8-1:0]       ex_be_i,
    input  logic                    commit_valid_i,
    input  logic [SB_IDX_WIDTH-1:0] commit_sb_id_i,
    input  logic                    flush_i,
    output logic                    dc_req_valid_o,
    input  logic                    dc_req_ready_i,
    output logic [PLEN-1:0]         dc_req_addr_o,
    output logic [XLEN-1:0]         dc_req_data_o,
    output logic [XLEN/8-1:0]       dc_req_be_o,
    output logic                    empty_o
);

    localparam int unsigned PW = SB_IDX_WIDTH + 1;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
    logic [PW-1:0] count;
    logic [SB_DEPTH-1:0] dv_q, dv_d;

    logic [SB_DEPTH-1:0][PLEN-1:0]   addr_q;
    logic [SB_DEPTH-1:0][XLEN-1:0]   data_q;
    logic [SB_DEPTH-1:0][XLEN/8-1:0] be_q;

    logic [SB_IDX_WIDTH-1:0] head_idx, cmt_idx, tail_idx, ex_off;
    logic ex_hit, alloc_fire, drain_fire;

    assign head_idx = head_q[SB_IDX_WIDTH-1:0];
    assign cmt_idx  = cmt_q[SB_IDX_WIDTH-1:0];
    assign tail_idx = tail_q[SB_IDX_WIDTH-1:0];
    assign count    = tail_q - head_q;

    assign alloc_gnt_o = (count != PW'(SB_DEPTH)) && !flush_i;
    assign alloc_id_o  = tail_idx;
    assign empty_o     = (head_q == tail_q);

    assign dc_req_valid_o = (head_q != cmt_q) && dv_q[head_idx];
    assign dc_req_addr_o  = dc_req_valid_o ? addr_q[head_idx] : '0;
    assign dc_req_data_o  = dc_req_valid_o ? data_q[head_idx] : '0;
    assign dc_req_be_o    = dc_req_valid_o ? be_q[head_idx] : '0;

    // Execute writes only land in the uncommitted window [cmt, tail).
    assign ex_off     = ex_sb_id_i - cmt_idx;
    assign ex_hit     = ex_valid_i && !flush_i && ({1'b0, ex_off} < (tail_q - cmt_q));
    assign alloc_fire = alloc_req_i && alloc_gnt_o;
    assign drain_fire = dc_req_valid_o && dc_req_ready_i;

    always_comb begin
        cmt_d  = cmt_q + PW'(commit_valid_i);
        head_d = head_q + PW'(drain_fire);
        tail_d = tail_q;
        dv_d   = dv_q;
        if (ex_hit) begin
            dv_d[ex_sb_id_i] = 1'b1;
        end
        if (drain_fire) begin
            dv_d[head_idx] = 1'b0;
        end
        if (flush_i) begin
            // Commit in the flush cycle is honoured first; everything younger is dropped.
            tail_d = cmt_d;
            for (int unsigned i = 0; i < SB_DEPTH; i++) begin
                if ({1'b0, SB_IDX_WIDTH'(i) - cmt_d[SB_IDX_WIDTH-1:0]} < (tail_q - cmt_d)) begin
                    dv_d[i] = 1'b0;
                end
            end
        end else if (alloc_fire) begin
            tail_d         = tail_q + PW'(1);
            dv_d[tail_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            cmt_q  <= '0;
            tail_q <= '0;
            dv_q   <= '0;
        end else begin
            head_q <= head_d;
            cmt_q  <= cmt_d;
            tail_q <= tail_d;
            dv_q   <= dv_d;
        end
    end

    // Payload is qualified by dv_q, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (ex_hit) begin
            addr_q[ex_sb_id_i] <= ex_addr_i;
            data_q[ex_sb_id_i] <= ex_data_i;
            be_q[ex_sb_id_i]   <= ex_be_i;
        end
    end

    a_commit_legal : assert property (@(posedge clk_i) disable iff (!rst_ni)
        commit_valid_i |-> (cmt_q != tail_q) && (commit_sb_id_i == cmt_idx) && dv_q[cmt_idx]);

    a_ptr_order : assert property (@(posedge clk_i) disable iff (!rst_ni)
        ((cmt_q - head_q) <= count) && (count <= PW'(SB_DEPTH)));

endmodule

// File: tb/tb_store_buffer.sv
// Randomised bench for store_buffer: queue-based reference model plus a drain scoreboard.
module tb_store_buffer;

    localparam int D = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alloc_req, alloc_gnt;
    logic [3:0]  alloc_id;
    logic        ex_valid;
    logic [3:0]  ex_id;
    logic [31:0] ex_addr, ex_data;
    logic [3:0]  ex_be;
    logic        commit_valid;
    logic [3:0]  commit_id;
    logic        flush;
    logic        dc_valid, dc_ready;
    logic [31:0] dc_addr, dc_data;
    logic [3:0]  dc_be;
    logic        empty;

    always #5 clk = ~clk;

    store_buffer #(.SB_DEPTH(D), .PLEN(32), .XLEN(32)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .alloc_req_i    (alloc_req),
        .alloc_gnt_o    (alloc_gnt),
        .alloc_id_o     (alloc_id),
        .ex_valid_i     (ex_valid),
        .ex_sb_id_i     (ex_id),
        .ex_addr_i      (ex_addr),
        .ex_data_i      (ex_data),
        .ex_be_i        (ex_be),
        .commit_valid_i (commit_valid),
        .commit_sb_id_i (commit_id),
        .flush_i        (flush),
        .dc_req_valid_o (dc_valid),
        .dc_req_ready_i (dc_ready),
        .dc_req_addr_o  (dc_addr),
        .dc_req_data_o  (dc_data),
        .dc_req_be_o    (dc_be),
        .empty_o        (empty)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        bit          dv;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } drn_t;

    // Model: mq holds live entries oldest first; the first ncmt of them are committed.
    ent_t mq[$];
    drn_t exp_q[$];
    int   ncmt;
    int   head_id;
    int   checks;
    int   passes;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    endtask

    function automatic int tail_id();
        return (head_id + mq.size()) % D;
    endfunction

    function automatic int cmt_id();
        return (head_id + ncmt) % D;
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        ncmt    = 0;
        head_id = 0;
    endtask

    task automatic model_step();
        bit gnt, drn;
        int pos;
        gnt = (mq.size() != D) && !flush;
        drn = (ncmt > 0) && dc_ready;
        if (ex_valid && !flush) begin
            pos = (int'(ex_id) - head_id + D) % D;
            if (pos >= ncmt && pos < mq.size()) begin
                mq[pos].addr = ex_addr;
                mq[pos].data = ex_data;
                mq[pos].be   = ex_be;
                mq[pos].dv   = 1'b1;
            end
        end
        if (commit_valid) begin
            exp_q.push_back('{addr: mq[ncmt].addr, data: mq[ncmt].data, be: mq[ncmt].be});
            ncmt++;
        end
        if (flush) begin
            while (mq.size() > ncmt) void'(mq.pop_back());
        end else if (alloc_req && gnt) begin
            mq.push_back('{addr: '0, data: '0, be: '0, dv: 1'b0});
        end
        if (drn) begin
            void'(mq.pop_front());
            ncmt--;
            head_id = (head_id + 1) % D;
        end
    endtask

    task automatic idle_inputs();
        alloc_req    = 1'b0;
        ex_valid     = 1'b0;
        ex_id        = '0;
        ex_addr      = '0;
        ex_data      = '0;
        ex_be        = '0;
        commit_valid = 1'b0;
        commit_id    = '0;
        flush        = 1'b0;
    endtask

    // Inputs are set by the caller after posedge; outputs checked mid-cycle.
    task automatic tick();
        @(negedge clk);
        chk("alloc_gnt", 64'(alloc_gnt), 64'((mq.size() != D) && !flush));
        chk("alloc_id", 64'(alloc_id), 64'(tail_id()));
        chk("empty", 64'(empty), 64'(mq.size() == 0));
        @(posedge clk);
        model_step();
        #1;
        idle_inputs();
    endtask

    task automatic ex_write(input int id);
        ex_valid = 1'b1;
        ex_id    = 4'(id);
        ex_addr  = $urandom;
        ex_data  = $urandom;
        ex_be    = 4'($urandom);
    endtask

    task automatic commit_next();
        commit_valid = 1'b1;
        commit_id    = 4'(cmt_id());
    endtask

    // Scoreboard monitor: drain requests must match committed stores in order.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("dc_valid", 64'(dc_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("dc_addr", 64'(dc_addr), 64'(exp_q[0].addr));
                chk("dc_data", 64'(dc_data), 64'(exp_q[0].data));
                chk("dc_be", 64'(dc_be), 64'(exp_q[0].be));
                if (dc_ready) void'(exp_q.pop_front());
            end else begin
                chk("dc_idle_fields", 64'(dc_addr | dc_data | 32'(dc_be)), 64'(0));
            end
        end
    end

    initial begin
        checks   = 0;
        passes   = 0;
        model_reset();
        idle_inputs();
        dc_ready = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_gnt", 64'(alloc_gnt), 64'(1));
        chk("reset_id", 64'(alloc_id), 64'(0));
        chk("reset_dc_valid", 64'(dc_valid), 64'(0));
        chk("reset_empty", 64'(empty), 64'(1));

        // Three back-to-back allocations, then discard them.
        repeat (3) begin
            alloc_req = 1'b1;
            tick();
        end
        flush = 1'b1;
        tick();

        // Single store through execute, commit and a stalled drain.
        alloc_req = 1'b1;
        tick();
        ex_valid = 1'b1;
        ex_id    = 4'(cmt_id());
        ex_addr  = 32'h8000_0010;
        ex_data  = 32'hDEAD_BEEF;
        ex_be    = 4'hF;
        tick();
        commit_next();
        tick();
        repeat (3) tick();
        dc_ready = 1'b1;
        tick();
        tick();
        chk("single_drain_empty", 64'(empty), 64'(1));

        // Fill to full, then free one slot by commit and drain.
        dc_ready = 1'b0;
        repeat (17) begin
            alloc_req = 1'b1;
            tick();
        end
        chk("full_gnt", 64'(alloc_gnt), 64'(0));
        ex_write(cmt_id());
        tick();
        commit_next();
        tick();
        dc_ready = 1'b1;
        tick();
        tick();
        alloc_req = 1'b1;
        tick();
        flush = 1'b1;
        tick();

        // Four allocated and written, two committed, then flush.
        dc_ready = 1'b0;
        repeat (4) begin
            alloc_req = 1'b1;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            ex_write((cmt_id() + i) % D);
            tick();
        end
        repeat (2) begin
            commit_next();
            tick();
        end
        flush = 1'b1;
        tick();
        dc_ready = 1'b1;
        repeat (3) tick();
        alloc_req = 1'b1;
        tick();
        flush = 1'b1;
        tick();

        // Commit and flush in the same cycle.
        dc_ready = 1'b0;
        repeat (3) begin
            alloc_req = 1'b1;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            ex_write((cmt_id() + i) % D);
            tick();
        end
        commit_next();
        tick();
        commit_next();
        flush = 1'b1;
        tick();
        dc_ready = 1'b1;
        repeat (3) tick();
        chk("cmt_flush_empty", 64'(empty), 64'(1));

        // Out-of-window write is ignored; then reset with a drain pending.
        dc_ready = 1'b0;
        repeat (3) begin
            alloc_req = 1'b1;
            tick();
        end
        ex_write((tail_id() + 2) % D);
        tick();
        tick();
        ex_write(cmt_id());
        tick();
        commit_next();
        tick();
        chk("pre_reset_valid", 64'(dc_valid), 64'(exp_q.size() != 0));
        rst_n = 1'b0;
        #1;
        chk("rst_dc_valid", 64'(dc_valid), 64'(0));
        chk("rst_alloc_id", 64'(alloc_id), 64'(0));
        chk("rst_empty", 64'(empty), 64'(1));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            alloc_req = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 99) < 50) begin
                if (mq.size() > ncmt && $urandom_range(0, 3) != 0)
                    ex_write((cmt_id() + $urandom_range(0, mq.size() - ncmt - 1)) % D);
                else
                    ex_write($urandom_range(0, D - 1));
            end
            if (mq.size() > ncmt && mq[ncmt].dv && $urandom_range(0, 99) < 40) commit_next();
            flush    = ($urandom_range(0, 99) < 3);
            dc_ready = ($urandom_range(0, 99) < 60);
            tick();
        end

        dc_ready = 1'b1;
        for (int c = 0; c < 64 && ncmt > 0; c++) tick();
        chk("final_drain_done", 64'(ncmt), 64'(0));
        flush = 1'b1;
        tick();
        tick();
        chk("final_scoreboard_empty", 64'(exp_q.size()), 64'(0));
        chk("final_empty", 64'(empty), 64'(1));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- In-order store buffer sitting directly downstream of rename's store-allocation handshake.
- Allocates one entry per cycle on rename request.
- Captures address, data and byte enables from the store execute unit.
- Marks entries committed in ROB order, then drains committed stores to the D-cache write port; flush discards all uncommitted entries.

Parameters:
- SB_DEPTH, 16, number of entries (power of two, ≥2)
- SB_IDX_WIDTH, $clog2(SB_DEPTH), entry index width
- PLEN, 32, physical address width
- XLEN, 32, store data width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- alloc_req_i  in  1  rename requests one entry this cycle
- alloc_gnt_o  out  1  entry available (combinational, independent of alloc_req_i)
- alloc_id_o  out  SB_IDX_WIDTH  index granted (tail index)
- ex_valid_i  in  1  execute writes store address/data
- ex_sb_id_i  in  SB_IDX_WIDTH  target entry
- ex_addr_i  in  PLEN  store address
- ex_data_i  in  XLEN  store data, byte-lane aligned
- ex_be_i  in  XLEN/8  byte enables
- commit_valid_i  in  1  ROB retires one store
- commit_sb_id_i  in  SB_IDX_WIDTH  entry being committed
- flush_i  in  1  pipeline flush
- dc_req_valid_o  out  1  drain request
- dc_req_ready_i  in  1  D-cache accepts
- dc_req_addr_o  out  PLEN  head address
- dc_req_data_o  out  XLEN  head data
- dc_req_be_o  out  XLEN/8  head byte enables
- empty_o  out  1  no allocated entries

Behaviour:
- Three pointers with an extra wrap bit each: head (oldest, drain), cmt (first uncommitted), tail (next alloc). Invariant: head ≤ cmt ≤ tail. count = tail − head, in range 0..SB_DEPTH.
- Per-entry state: data_valid bit plus addr/data/be storage.
- Reset: all pointers 0, all data_valid 0. Outputs after reset: alloc_gnt_o=1, alloc_id_o=0, dc_req_valid_o=0, empty_o=1.
- Alloc:
  - alloc_gnt_o = (count != SB_DEPTH) && !flush_i.
  - alloc_id_o = tail[SB_IDX_WIDTH-1:0].
  - On alloc_req_i && alloc_gnt_o: tail += 1 and the entry's data_valid is cleared.
  - A drain in the same cycle does not free a slot for alloc; there is no ready-through path.
- Execute write:
  - On ex_valid_i && !flush_i with ex_sb_id_i in [cmt, tail): store addr/data/be and set data_valid.
  - Writes outside that range are ignored. Re-writing an entry overwrites it.
- Commit:
  - On commit_valid_i: cmt += 1.
  - commit_sb_id_i must equal cmt index and that entry must be data_valid; violations fire an assertion. At most one commit per cycle.
  - Commit with cmt == tail is illegal (assertion).
- Drain:
  - dc_req_valid_o = (head != cmt) && data_valid[head].
  - dc_req_addr/data/be are combinational from the head entry; they are 0 when dc_req_valid_o=0.
  - On valid && ready: head += 1 and data_valid[head] is cleared. One drain per cycle.
  - dc_req_valid_o stays high and the head fields stay stable until accepted, including during flush.
- Flush:
  - At the clock edge, tail ← cmt_next (cmt after this cycle's commit).
  - data_valid is cleared for every entry in [cmt_next, old tail).
  - Committed entries are preserved and keep draining.
  - Alloc and execute write are suppressed in the flush cycle; a commit in the same cycle is honoured first.
- Wrap: all pointers wrap modulo SB_DEPTH in the index field; the extra wrap bit distinguishes full (index equal, wrap differs) from empty.
- empty_o = (head == tail), including the wrap bit.
- Reset mid-operation: all state clears asynchronously, and any pending drain request is dropped.

Test Plan:
- Reset, then 3 alloc requests → alloc_id_o 0,1,2 on successive cycles; gnt stays 1; empty_o deasserts after the first grant.
- Alloc id 0; ex write addr 0x8000_0010, data 0xDEADBEEF, be 0xF; commit id 0 → next cycle dc_req_valid_o=1 with those fields. Hold ready=0 for 3 cycles → fields stable. Ready=1 → head advances, empty_o=1.
- Alloc 16 without commit → alloc_gnt_o=0 at count 16. Commit and drain 1 with ready=1 → gnt returns to 1 the cycle after the drain; alloc_id_o=0 (wrap).
- Alloc 4, ex write all 4, commit 2, flush → tail=2, entries 2–3 invalid, entries 0–1 still drain. Next alloc gets id 2.
- commit_valid_i and flush_i in the same cycle with cmt=1, tail=3 → cmt=2, tail=2; 2 entries drain afterwards.
- Ex write to id 5 when tail=3 → ignored, no drain. Assert rst_ni low while dc_req_valid_o=1 → dc_req_valid_o=0 immediately, alloc_id_o=0, empty_o=1.
